// File: rtl/punc_lsu_pkg.sv
// Shared types for the PUnC load/store unit.
// Op codes and FSM state encodings.
package punc_lsu_pkg;

  typedef enum logic [1:0] {
    LSU_OP_LD  = 2'b00,
    LSU_OP_ST  = 2'b01,
    LSU_OP_LDI = 2'b10,
    LSU_OP_STI = 2'b11
  } lsu_op_e;

  typedef enum logic [2:0] {
    LSU_IDLE = 3'd0,
    LSU_RD   = 3'd1,
    LSU_WAIT = 3'd2,
    LSU_WR   = 3'd3,
    LSU_RESP = 3'd4
  } lsu_state_e;

endpackage

// File: rtl/punc_lsu_addr_gen.sv
// Effective address (base + sign-extended offset, wrapping)
// and out-of-range flags for the effective address and a pointer.
module punc_lsu_addr_gen #(
  parameter int ADDR_W    = 16,
  parameter int OFF_W     = 9,
  parameter int MEM_DEPTH = 1024
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [OFF_W-1:0]  off,
  input  logic [ADDR_W-1:0] ptr,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_oob,
  output logic              ptr_oob
);

  logic [ADDR_W-1:0] off_ext;

  assign off_ext  = {{(ADDR_W-OFF_W){off[OFF_W-1]}}, off};
  assign addr     = base + off_ext;
  assign addr_oob = 64'(addr) >= 64'(MEM_DEPTH);
  assign ptr_oob  = 64'(ptr) >= 64'(MEM_DEPTH);

endmodule

// File: rtl/punc_lsu.sv
// PUnC load/store unit: LD/ST/LDI/STI over a 1-cycle sync memory.
// Optional bounds checking with `define PUNC_LSU_BOUNDS_EN.
module punc_lsu
  import punc_lsu_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int OFF_W     = 9,
  parameter int MEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [OFF_W-1:0]  req_off,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [2:0]        rsp_nzp,
  output logic              rsp_err,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_r_addr,
  input  logic [DATA_W-1:0] mem_r_data,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic [DATA_W-1:0] mem_w_data
);

`ifdef PUNC_LSU_BOUNDS_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  lsu_state_e        state_q, state_d;
  lsu_op_e           op_q;
  logic              ind_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        nzp_q;
  logic              err_q;

  logic [ADDR_W-1:0] ea;
  logic              ea_oob;
  logic              ptr_oob;
  logic              accept;
  logic              ea_bad;
  logic              ptr_bad;
  logic [2:0]        rd_nzp;

  punc_lsu_addr_gen #(
    .ADDR_W   (ADDR_W),
    .OFF_W    (OFF_W),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_addr_gen (
    .base    (req_base),
    .off     (req_off),
    .ptr     (mem_r_data[ADDR_W-1:0]),
    .addr    (ea),
    .addr_oob(ea_oob),
    .ptr_oob (ptr_oob)
  );

  assign accept  = req_valid && (state_q == LSU_IDLE);
  assign ea_bad  = BOUNDS_EN && ea_oob;
  assign ptr_bad = BOUNDS_EN && ptr_oob;

  always_comb begin
    rd_nzp    = 3'b000;
    rd_nzp[2] = mem_r_data[DATA_W-1];
    rd_nzp[1] = (mem_r_data == '0);
    rd_nzp[0] = ~rd_nzp[2] & ~rd_nzp[1];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LSU_IDLE: begin
        if (req_valid) begin
          if (ea_bad)
            state_d = LSU_RESP;
          else if (lsu_op_e'(req_op) == LSU_OP_ST)
            state_d = LSU_WR;
          else
            state_d = LSU_RD;
        end
      end
      LSU_RD:   state_d = LSU_WAIT;
      LSU_WAIT: begin
        if (!ind_q)
          state_d = LSU_RESP;
        else if (ptr_bad)
          state_d = LSU_RESP;
        else if (op_q == LSU_OP_STI)
          state_d = LSU_WR;
        else
          state_d = LSU_RD;
      end
      LSU_WR:   state_d = LSU_RESP;
      LSU_RESP: if (rsp_ready) state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LSU_IDLE;
      op_q    <= LSU_OP_LD;
      ind_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      wdata_q <= '0;
      nzp_q   <= 3'b000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= lsu_op_e'(req_op);
        ind_q   <= req_op[1];
        addr_q  <= ea;
        wdata_q <= req_wdata;
        data_q  <= '0;
        nzp_q   <= 3'b000;
        err_q   <= ea_bad;
      end else if (state_q == LSU_WAIT) begin
        if (ind_q) begin
          // first read of an indirect op returns the pointer
          ind_q  <= 1'b0;
          addr_q <= mem_r_data[ADDR_W-1:0];
          err_q  <= ptr_bad;
        end else begin
          data_q <= mem_r_data;
          nzp_q  <= rd_nzp;
        end
      end
    end
  end

  assign req_ready  = (state_q == LSU_IDLE);
  assign rsp_valid  = (state_q == LSU_RESP);
  assign rsp_data   = data_q;
  assign rsp_nzp    = nzp_q;
  assign mem_re     = (state_q == LSU_RD);
  assign mem_r_addr = mem_re ? addr_q : '0;
  assign mem_w_en   = (state_q == LSU_WR);
  assign mem_w_addr = mem_w_en ? addr_q : '0;
  assign mem_w_data = mem_w_en ? wdata_q : '0;

`ifdef PUNC_LSU_BOUNDS_EN
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_punc_lsu.sv
// Self-checking bench for punc_lsu against a behavioural model.
// Honours `define PUNC_LSU_BOUNDS_EN (MEM_DEPTH 1024).
module tb_punc_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_base;
  logic [8:0]  req_off;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_nzp;
  logic        rsp_err;
  logic        mem_re;
  logic [15:0] mem_r_addr;
  logic [15:0] mem_r_data;
  logic        mem_w_en;
  logic [15:0] mem_w_addr;
  logic [15:0] mem_w_data;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic [15:0] rd_log[$];
  logic [15:0] wa_log[$];
  logic [15:0] wd_log[$];

  punc_lsu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_base  (req_base),
    .req_off   (req_off),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_nzp   (rsp_nzp),
    .rsp_err   (rsp_err),
    .mem_re    (mem_re),
    .mem_r_addr(mem_r_addr),
    .mem_r_data(mem_r_data),
    .mem_w_en  (mem_w_en),
    .mem_w_addr(mem_w_addr),
    .mem_w_data(mem_w_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous memory with 1-cycle read latency, plus access log
  always @(posedge clk) begin
    if (mem_re) begin
      mem_r_data <= mem[mem_r_addr];
      rd_log.push_back(mem_r_addr);
    end
    if (mem_w_en) begin
      mem[mem_w_addr] <= mem_w_data;
      wa_log.push_back(mem_w_addr);
      wd_log.push_back(mem_w_data);
    end
  end

  function automatic bit oob(input logic [15:0] a);
`ifdef PUNC_LSU_BOUNDS_EN
    return a >= 16'd1024;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [2:0] nzp_of(input logic [15:0] d);
    if ($signed(d) < 0) return 3'b100;
    if (d == 16'h0)     return 3'b010;
    return 3'b001;
  endfunction

  // Architectural model: what a request should do, in plain terms.
  task automatic model(
    input  logic [1:0]  op,
    input  logic [15:0] base,
    input  logic [8:0]  off,
    input  logic [15:0] wd,
    output logic [15:0] e_data,
    output logic [2:0]  e_nzp,
    output logic        e_err,
    output int          e_lat,
    output int          e_nr,
    output logic [15:0] e_rd [2],
    output int          e_nw,
    output logic [15:0] e_wa
  );
    logic [15:0] a, p;
    bit is_load, ind;
    a = base + {{7{off[8]}}, off};
    is_load = (op[0] == 1'b0);
    ind = op[1];
    e_data = 16'h0; e_nzp = 3'b000; e_err = 1'b0;
    e_nr = 0; e_nw = 0; e_wa = 16'h0;
    e_rd[0] = 16'h0; e_rd[1] = 16'h0;
    if (oob(a)) begin
      e_err = 1'b1; e_lat = 1;
      return;
    end
    if (ind) begin
      e_rd[0] = a; e_nr = 1;
      p = ref_mem[a];
      if (oob(p)) begin
        e_err = 1'b1; e_lat = 3;
        return;
      end
      a = p;
    end
    if (is_load) begin
      e_rd[e_nr] = a; e_nr++;
      e_data = ref_mem[a];
      e_nzp = nzp_of(e_data);
      e_lat = ind ? 5 : 3;
    end else begin
      e_wa = a; e_nw = 1;
      ref_mem[a] = wd;
      e_lat = ind ? 4 : 2;
    end
  endtask

  task automatic do_req(
    input logic [1:0]  op,
    input logic [15:0] base,
    input logic [8:0]  off,
    input logic [15:0] wd,
    input int          hold,
    input string       tag
  );
    logic [15:0] e_data, e_wa;
    logic [2:0]  e_nzp;
    logic        e_err;
    int e_lat, e_nr, e_nw, lat, r0, w0;
    logic [15:0] e_rd [2];
    model(op, base, off, wd, e_data, e_nzp, e_err, e_lat, e_nr, e_rd, e_nw, e_wa);
    r0 = rd_log.size();
    w0 = wa_log.size();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready: got %b want 1", tag, req_ready);
    end
    req_op = op; req_base = base; req_off = off; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_base = $urandom; req_off = 9'($urandom);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 16) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: no rsp_valid after %0d cycles", tag, lat);
      return;
    end
    checks++;
    if (lat != e_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, e_lat);
    end
    checks++;
    if (rsp_data !== e_data || rsp_nzp !== e_nzp || rsp_err !== e_err) begin
      errors++;
      $display("FAIL %s rsp: got %h/%b/%b want %h/%b/%b", tag,
               rsp_data, rsp_nzp, rsp_err, e_data, e_nzp, e_err);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 ||
          rsp_data !== e_data || rsp_nzp !== e_nzp) begin
        errors++;
        $display("FAIL %s hold%0d: v=%b rdy=%b d=%h nzp=%b want 1 0 %h %b",
                 tag, i, rsp_valid, req_ready, rsp_data, rsp_nzp, e_data, e_nzp);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s release: rdy=%b v=%b want 1 0", tag, req_ready, rsp_valid);
    end
    checks++;
    if (rd_log.size() - r0 != e_nr ||
        (e_nr > 0 && rd_log[r0] !== e_rd[0]) ||
        (e_nr > 1 && rd_log[r0+1] !== e_rd[1])) begin
      errors++;
      $display("FAIL %s reads: got %0d reads (first %h) want %0d (%h %h)", tag,
               rd_log.size() - r0, (rd_log.size() > r0) ? rd_log[r0] : 16'h0,
               e_nr, e_rd[0], e_rd[1]);
    end
    checks++;
    if (wa_log.size() - w0 != e_nw ||
        (e_nw > 0 && (wa_log[w0] !== e_wa || wd_log[w0] !== wd))) begin
      errors++;
      $display("FAIL %s writes: got %0d writes want %0d at %h data %h", tag,
               wa_log.size() - w0, e_nw, e_wa, wd);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    mem[a] = d;
    ref_mem[a] = d;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = 2'b00; req_base = '0; req_off = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_re !== 1'b0 ||
        mem_w_en !== 1'b0 || rsp_data !== 16'h0 || rsp_nzp !== 3'b000 ||
        rsp_err !== 1'b0 || mem_r_addr !== 16'h0 || mem_w_addr !== 16'h0) begin
      errors++;
      $display("FAIL reset: rdy=%b v=%b re=%b we=%b d=%h nzp=%b err=%b",
               req_ready, rsp_valid, mem_re, mem_w_en, rsp_data, rsp_nzp, rsp_err);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    poke(16'h0105, 16'h8001);
    do_req(2'b00, 16'h0100, 9'd5, 16'h0, 0, "ld_neg");
    do_req(2'b01, 16'h0010, 9'h1FF, 16'h1234, 0, "st_negoff");
    poke(16'h0020, 16'h0040);
    poke(16'h0040, 16'h0000);
    do_req(2'b10, 16'h0020, 9'd0, 16'h0, 0, "ldi_zero");
    do_req(2'b00, 16'hFFFF, 9'd2, 16'h0, 4, "ld_wrap_hold");
    do_req(2'b11, 16'h0020, 9'd0, 16'h7777, 1, "sti");
    do_req(2'b01, 16'h0400, 9'd0, 16'h5A5A, 0, "st_0400");
    do_req(2'b00, 16'h03FF, 9'd0, 16'h0, 0, "ld_03ff");
    poke(16'h0030, 16'h0400);
    do_req(2'b10, 16'h0030, 9'd0, 16'h0, 0, "ldi_ptr_oob");
  endtask

  task automatic test_reset_mid_sti;
    int n;
    poke(16'h0050, 16'h0060);
    poke(16'h0060, 16'h1111);
    req_op = 2'b11; req_base = 16'h0050; req_off = 9'd0; req_wdata = 16'hBEEF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (mem_w_en !== 1'b1 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (mem_w_en !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid timeout: no mem_w_en after %0d cycles", n);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_w_en !== 1'b0 || mem_w_addr !== 16'h0 || mem_w_data !== 16'h0 ||
        mem_re !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1 ||
        rsp_data !== 16'h0 || rsp_nzp !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid outputs: we=%b wa=%h re=%b v=%b rdy=%b d=%h",
               mem_w_en, mem_w_addr, mem_re, rsp_valid, req_ready, rsp_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mem[16'h0060] !== 16'h1111) begin
      errors++;
      $display("FAIL rst_mid nowrite: mem[0060]=%h want 1111", mem[16'h0060]);
    end
    do_req(2'b11, 16'h0050, 9'd0, 16'hBEEF, 0, "sti_after_rst");
  endtask

  task automatic test_random;
    logic [15:0] b;
    for (int i = 0; i < 150; i++) begin
      b = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1023));
      do_req(2'($urandom_range(0, 3)), b, 9'($urandom), 16'($urandom),
             $urandom_range(0, 2), "rand");
    end
  endtask

  task automatic test_mem_image;
    int bad;
    bad = 0;
    for (int i = 0; i < 65536; i++)
      if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mem_image: %0d words differ, want 0", bad);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1023));
      ref_mem[i] = mem[i];
    end
    mem_r_data = 16'h0;
    test_reset();
    test_directed();
    test_reset_mid_sti();
    test_random();
    test_mem_image();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
